// File: rtl/p1_shift_pkg.sv
// p1_shift_pkg: shared FSM state type and mode constants for the P1 shifter family
package p1_shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic MODE_LOGICAL = 1'b0;
  localparam logic MODE_ARITH   = 1'b1;
endpackage

// File: rtl/p1_enc_norm_detect.sv
// p1_enc_norm_detect: zero/normalized detection of the working word (arith path only with P1_ENC_ARITH_EN)
module p1_enc_norm_detect
  import p1_shift_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             is_zero,
  output logic             is_norm
);
  assign is_zero = ~|data;
`ifdef P1_ENC_ARITH_EN
  // logical wants a leading one, arithmetic wants sign and next bit to differ
  always_comb is_norm = (mode == MODE_ARITH) ? (data[WIDTH-1] ^ data[WIDTH-2]) : data[WIDTH-1];
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  // only the logical leading-one test exists in this build
  always_comb is_norm = data[WIDTH-1];
`endif
endmodule

// File: rtl/p1_enc_norm_shift.sv
// p1_enc_norm_shift: sequential normalizing shifter with shift-count encoder; arithmetic mode gated by P1_ENC_ARITH_EN
module p1_enc_norm_shift
  import p1_shift_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shamt,
  output logic             zero
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mode, w_is_zero, w_is_norm, w_accept, w_zero_hit, w_cap, w_fin;
`ifdef P1_ENC_ARITH_EN
  logic r_mode;
  // mode is latched with the accepted operand
  always_ff @(posedge clk)
    if (rst) r_mode <= MODE_LOGICAL;
    else if (w_accept) r_mode <= mode;
  assign w_mode = r_mode;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_mode = MODE_LOGICAL;
`endif
  p1_enc_norm_detect #(.WIDTH(WIDTH)) u_detect (
    .data    (r_work),
    .mode    (w_mode),
    .is_zero (w_is_zero),
    .is_norm (w_is_norm)
  );
  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_zero_hit = w_is_zero && (r_cnt == '0);
  assign w_cap      = r_cnt == CNT_W'(WIDTH - 1);
  assign w_fin      = (r_state == SHIFT) && (w_zero_hit || w_is_norm || w_cap);
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: accept wins in IDLE/DONE, SHIFT runs until a finish condition
  always_comb
    w_next = w_accept ? SHIFT : (r_state == SHIFT) ? (w_fin ? DONE : SHIFT) : IDLE;
  // status outputs decoded from the state register only
  always_comb begin
    busy = r_state == SHIFT;
    done = r_state == DONE;
  end
  // working register, counter and result registers; results persist until next completion
  always_ff @(posedge clk)
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      dout   <= '0;
      shamt  <= '0;
      zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_work <= din;
        r_cnt  <= '0;
      end else if (r_state == SHIFT && !w_fin) begin
        r_work <= r_work << 1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_fin) begin
        dout  <= w_zero_hit ? '0 : r_work;
        shamt <= w_zero_hit ? CNT_W'(WIDTH) : r_cnt;
        zero  <= w_zero_hit;
      end
    end
endmodule

// File: tb/tb_p1_enc_norm_shift.sv
// tb_p1_enc_norm_shift: randomized and directed checks against a count-leading-bits reference model
module tb_p1_enc_norm_shift;
  logic       clk = 1'b0;
  logic       rst, start, mode, busy, done, zero;
  logic [4:0] din, dout;
  logic [2:0] shamt;
  int         checks = 0, failures = 0;
  int         prev_dout = 0, prev_shamt = 0, prev_zero = 0;

  p1_enc_norm_shift #(.WIDTH(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .mode(mode),
    .busy(busy), .done(done), .dout(dout), .shamt(shamt), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] x, input logic m,
                                output int d, output int s, output int z);
    int  k = 0;
    logic am = m;
`ifndef P1_ENC_ARITH_EN
    am = 1'b0;
`endif
    if (x == 0) begin
      d = 0; s = 5; z = 1;
      return;
    end
    if (!am) while (!x[4-k]) k++;
    else while (k < 4 && x[3-k] == x[4]) k++;
    d = int'(5'(x << k));
    s = k;
    z = 0;
  endfunction

  task automatic issue(input logic [4:0] d, input logic m);
    start = 1'b1; din = d; mode = m;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_check(input logic [4:0] d, input logic m, input bit poke, input string tag);
    int ed, es, ez, n = 0;
    model(d, m, ed, es, ez);
    while (n < 20) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (n == 0) begin
        chk({tag, "_hold_dout"}, dout, prev_dout);
        chk({tag, "_hold_shamt"}, shamt, prev_shamt);
        if (poke) begin
          start = 1'b1; din = ~d; mode = ~m;
        end
      end
      if (!busy) chk({tag, "_busy"}, busy, 1);
      n++;
    end
    chk({tag, "_lat"}, n, (ez ? 0 : es) + 1);
    chk({tag, "_dout"}, dout, ed);
    chk({tag, "_shamt"}, shamt, es);
    chk({tag, "_zero"}, zero, ez);
    if (busy) chk({tag, "_busy_done"}, busy, 0);
    prev_dout = ed; prev_shamt = es; prev_zero = ez;
  endtask

  task automatic run(input logic [4:0] d, input logic m, input string tag);
    @(negedge clk);
    issue(d, m);
    finish_check(d, m, 1'b0, tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_dout"}, dout, prev_dout);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_shamt", shamt, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    run(5'b00101, 1'b0, "log_00101");
    run(5'b10100, 1'b0, "log_10100");
    run(5'b00000, 1'b0, "log_zero");
    run(5'b11101, 1'b1, "ar_11101");
    run(5'b00011, 1'b1, "ar_00011");
    run(5'b11111, 1'b1, "ar_11111");
    run(5'b00000, 1'b1, "ar_zero");
    run(5'b00001, 1'b0, "log_00001");
    @(negedge clk);
    issue(5'b00101, 1'b0);
    finish_check(5'b00101, 1'b0, 1'b1, "ignore");
    issue(5'b01000, 1'b0);
    finish_check(5'b01000, 1'b0, 1'b0, "b2b");
    @(negedge clk);
    chk("b2b_done_pulse", done, 0);
    issue(5'b00001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_shamt", shamt, 0);
    chk("mid_rst_zero", zero, 0);
    prev_dout = 0; prev_shamt = 0; prev_zero = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) chk("mid_rst_no_done", done, 0);
    end
    for (int i = 0; i < 60; i++)
      run(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
